// File: rtl/bs_rotate_collector_if.sv
// Handshake bundle between the barrel-shifter output, the nibble collector
// and the downstream consumer of packed words.
interface bs_rotate_collector_if #(
    parameter int DW = 4,
    parameter int N  = 4
) ();
    // rotator side
    logic [DW-1:0]   i_Y;
    logic            i_valid;
    logic            o_ready;
    logic            i_flush;
    // consumer side
    logic [DW*N-1:0] o_word;
    logic [3:0]      o_nvld;
    logic            o_valid;
    logic            i_ready;
    logic [7:0]      o_wcnt;

    // collector view
    modport slave (
        input  i_Y, i_valid, i_flush, i_ready,
        output o_ready, o_word, o_nvld, o_valid, o_wcnt
    );

    // environment view (rotator + consumer)
    modport master (
        output i_Y, i_valid, i_flush, i_ready,
        input  o_ready, o_word, o_nvld, o_valid, o_wcnt
    );
endinterface

// File: rtl/bs_rotate_collector.sv
// Nibble collector behind the 4-bit rotate-right barrel shifter.
// Packs N accepted results LSB-first into one word, presents it on a
// registered valid/ready output and counts delivered words. A level flush
// request emits the partial pack zero-padded in the unfilled upper nibbles.
module bs_rotate_collector #(
    parameter int DW = 4,
    parameter int N  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    bs_rotate_collector_if.slave    bus
);

    localparam int            WW   = DW * N;
    localparam logic [3:0]    LAST = 4'(N - 1);

    // Output register occupancy
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    out_state_t      ostate_q, ostate_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [WW-1:0]   pk_q, pk_d;
    logic [WW-1:0]   word_q, word_d;
    logic [3:0]      nvld_q, nvld_d;
    logic [7:0]      wcnt_q, wcnt_d;

    logic            out_valid;
    logic            in_ready;
    logic            acc;
    logic            ohs;
    logic            pack_full;
    logic            flush_take;
    logic            push;
    logic [3:0]      filled;
    logic [WW-1:0]   pk_merged;

    assign out_valid = (ostate_q == OUT_FULL);

    // Stall only when the pack is about to complete and the output slot is
    // still occupied; deliberately independent of i_ready so there is no
    // combinational path through the collector.
    assign in_ready  = ~(out_valid & (cnt_q == LAST));

    assign acc       = bus.i_valid & in_ready;
    assign ohs       = out_valid & bus.i_ready;
    assign pack_full = acc & (cnt_q == LAST);

    // A flush only acts on a non-empty pack (or one becoming non-empty this
    // cycle) and waits for the output slot to be free, so a push never
    // collides with a pending word.
    assign flush_take = bus.i_flush & ~out_valid & ((cnt_q != 4'd0) | acc);
    assign push       = pack_full | flush_take;

    // Number of slots that hold data once this cycle's nibble is included
    assign filled = cnt_q + {3'b000, acc};

    // Pack register with this cycle's accepted nibble dropped into slot cnt
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            localparam logic [3:0] SLOT = 4'(gi);
            assign pk_merged[gi*DW +: DW] = (acc && (cnt_q == SLOT)) ? bus.i_Y
                                                                      : pk_q[gi*DW +: DW];
        end
    endgenerate

    // Output-slot FSM next state: a push fills it, a handshake drains it
    always_comb begin
        ostate_d = ostate_q;
        case (ostate_q)
            OUT_EMPTY: begin
                if (push) begin
                    ostate_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (ohs) begin
                    ostate_d = OUT_EMPTY;
                end
            end
            default: ostate_d = OUT_EMPTY;
        endcase
    end

    // Pack, output word and word-count next state
    always_comb begin
        cnt_d  = cnt_q;
        pk_d   = pk_q;
        word_d = word_q;
        nvld_d = nvld_q;
        wcnt_d = wcnt_q;

        if (ohs) begin
            wcnt_d = wcnt_q + 8'd1;
        end

        if (push) begin
            word_d = pk_merged;
            nvld_d = filled;
            cnt_d  = 4'd0;
            pk_d   = '0;
        end else if (acc) begin
            pk_d  = pk_merged;
            cnt_d = cnt_q + 4'd1;
        end
    end

    // State register; reset discards any partial pack and pending word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ostate_q <= OUT_EMPTY;
            cnt_q    <= 4'd0;
            pk_q     <= '0;
            word_q   <= '0;
            nvld_q   <= 4'd0;
            wcnt_q   <= 8'd0;
        end else begin
            ostate_q <= ostate_d;
            cnt_q    <= cnt_d;
            pk_q     <= pk_d;
            word_q   <= word_d;
            nvld_q   <= nvld_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign bus.o_ready = in_ready;
    assign bus.o_valid = out_valid;
    assign bus.o_word  = word_q;
    assign bus.o_nvld  = nvld_q;
    assign bus.o_wcnt  = wcnt_q;

endmodule

// File: tb/tb_bs_rotate_collector.sv
// Directed bench for bs_rotate_collector with N=4, DW=4.
module tb_bs_rotate_collector;

    logic clk;
    logic rst;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    bs_rotate_collector_if #(.DW(4), .N(4)) bus ();

    bs_rotate_collector #(.DW(4), .N(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  y;
        logic        f;
        logic        r;
        logic        e_rdy;
        logic        e_v;
        logic [15:0] e_w;
        logic [3:0]  e_n;
        logic [7:0]  e_c;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [3:0] y, input logic f,
                                input logic r, input logic e_rdy, input logic e_v,
                                input logic [15:0] e_w, input logic [3:0] e_n,
                                input logic [7:0] e_c);
        vec_t t;
        t.v = v; t.y = y; t.f = f; t.r = r;
        t.e_rdy = e_rdy; t.e_v = e_v; t.e_w = e_w; t.e_n = e_n; t.e_c = e_c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: o_ready is checked before the edge (it depends
    // on registered state only), the output register just after the edge.
    task automatic step(input string tag, input vec_t t, input bit verbose);
        @(negedge clk);
        bus.i_valid = t.v;
        bus.i_Y     = t.y;
        bus.i_flush = t.f;
        bus.i_ready = t.r;
        #1;
        chk({tag, ".o_ready"}, 32'(bus.o_ready), 32'(t.e_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".o_valid"}, 32'(bus.o_valid), 32'(t.e_v));
        chk({tag, ".o_wcnt"},  32'(bus.o_wcnt),  32'(t.e_c));
        if (t.e_v) begin
            chk({tag, ".o_word"}, 32'(bus.o_word), 32'(t.e_w));
            chk({tag, ".o_nvld"}, 32'(bus.o_nvld), 32'(t.e_n));
        end
        if (verbose)
            $display("%s: v=%0b y=%0h f=%0b r=%0b -> valid=%0b word=%04h nvld=%0d wcnt=%0d",
                     tag, t.v, t.y, t.f, t.r, bus.o_valid, bus.o_word, bus.o_nvld, bus.o_wcnt);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".o_valid"}, 32'(bus.o_valid), 32'd0);
        chk({tag, ".o_word"},  32'(bus.o_word),  32'd0);
        chk({tag, ".o_nvld"},  32'(bus.o_nvld),  32'd0);
        chk({tag, ".o_wcnt"},  32'(bus.o_wcnt),  32'd0);
        chk({tag, ".o_ready"}, 32'(bus.o_ready), 32'd1);
    endtask

    initial begin
        // basic pack 1,2,3,4
        tbl.push_back(mk(1, 4'h1, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 4'h2, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 4'h3, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 4'h4, 0, 1, 1, 1, 16'h4321, 4, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 0, 1));
        // backpressure: 1..8 with consumer stalled
        tbl.push_back(mk(1, 4'h1, 0, 0, 1, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(1, 4'h2, 0, 0, 1, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(1, 4'h3, 0, 0, 1, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(1, 4'h4, 0, 0, 1, 1, 16'h4321, 4, 1));
        tbl.push_back(mk(1, 4'h5, 0, 0, 1, 1, 16'h4321, 4, 1));
        tbl.push_back(mk(1, 4'h6, 0, 0, 1, 1, 16'h4321, 4, 1));
        tbl.push_back(mk(1, 4'h7, 0, 0, 1, 1, 16'h4321, 4, 1));
        tbl.push_back(mk(1, 4'h8, 0, 0, 0, 1, 16'h4321, 4, 1));
        tbl.push_back(mk(1, 4'h8, 0, 1, 0, 0, 16'h0000, 0, 2));
        tbl.push_back(mk(1, 4'h8, 0, 1, 1, 1, 16'h8765, 4, 2));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 0, 3));
        // flush partial A,B; then flush on empty pack is a no-op
        tbl.push_back(mk(1, 4'hA, 0, 1, 1, 0, 16'h0000, 0, 3));
        tbl.push_back(mk(1, 4'hB, 0, 1, 1, 0, 16'h0000, 0, 3));
        tbl.push_back(mk(0, 4'h0, 1, 1, 1, 1, 16'h00BA, 2, 3));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 0, 4));
        tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 16'h0000, 0, 4));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 0, 4));
        // flush in the same cycle as an accept; pack restarts at slot 0
        tbl.push_back(mk(1, 4'h5, 0, 1, 1, 0, 16'h0000, 0, 4));
        tbl.push_back(mk(1, 4'h6, 1, 1, 1, 1, 16'h0065, 2, 4));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 0, 5));
        tbl.push_back(mk(1, 4'h7, 1, 1, 1, 1, 16'h0007, 1, 5));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 0, 6));
        // flush held off while the output word is pending
        tbl.push_back(mk(1, 4'h1, 0, 0, 1, 0, 16'h0000, 0, 6));
        tbl.push_back(mk(1, 4'h2, 0, 0, 1, 0, 16'h0000, 0, 6));
        tbl.push_back(mk(1, 4'h3, 0, 0, 1, 0, 16'h0000, 0, 6));
        tbl.push_back(mk(1, 4'h4, 0, 0, 1, 1, 16'h4321, 4, 6));
        tbl.push_back(mk(1, 4'h9, 0, 0, 1, 1, 16'h4321, 4, 6));
        tbl.push_back(mk(1, 4'hC, 0, 0, 1, 1, 16'h4321, 4, 6));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 1, 16'h4321, 4, 6));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 1, 16'h4321, 4, 6));
        tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 16'h0000, 0, 7));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 1, 16'h00C9, 2, 7));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 0, 8));

        // reset
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_Y     = 4'h0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle_outputs("reset");
        $display("reset released: valid=%0b ready=%0b wcnt=%0d", bus.o_valid, bus.o_ready, bus.o_wcnt);

        // directed table
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i], 1'b1);
        end

        // sustained full-rate packing up to the word-count wrap (8 -> 256)
        for (int w = 0; w < 248; w++) begin
            for (int k = 0; k < 4; k++) begin
                step($sformatf("wrap%0d.%0d", w, k),
                     mk(1, 4'(k + 1), 0, 1, 1, (k == 3), 16'h4321, 4, 8'(8 + w)),
                     1'b0);
            end
            $display("wrap word %0d: word=%04h wcnt=%0d", w, bus.o_word, bus.o_wcnt);
        end
        step("wrap_end", mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 0, 8'd0), 1'b1);

        // asynchronous reset mid-operation: pending word plus cnt=2
        step("rst0", mk(1, 4'h3, 1, 0, 1, 1, 16'h0003, 1, 0), 1'b1);
        step("rst1", mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 0, 1), 1'b1);
        step("rst2", mk(1, 4'h1, 0, 0, 1, 0, 16'h0000, 0, 1), 1'b1);
        step("rst3", mk(1, 4'h2, 0, 0, 1, 0, 16'h0000, 0, 1), 1'b1);
        step("rst4", mk(1, 4'h3, 0, 0, 1, 0, 16'h0000, 0, 1), 1'b1);
        step("rst5", mk(1, 4'h4, 0, 0, 1, 1, 16'h4321, 4, 1), 1'b1);
        step("rst6", mk(1, 4'h5, 0, 0, 1, 1, 16'h4321, 4, 1), 1'b1);
        step("rst7", mk(1, 4'h6, 0, 0, 1, 1, 16'h4321, 4, 1), 1'b1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        $display("async reset: valid=%0b word=%04h nvld=%0d wcnt=%0d ready=%0b",
                 bus.o_valid, bus.o_word, bus.o_nvld, bus.o_wcnt, bus.o_ready);
        @(negedge clk);
        rst = 1'b0;
        step("post0", mk(1, 4'h1, 0, 1, 1, 0, 16'h0000, 0, 0), 1'b1);
        step("post1", mk(1, 4'h2, 0, 1, 1, 0, 16'h0000, 0, 0), 1'b1);
        step("post2", mk(1, 4'h3, 0, 1, 1, 0, 16'h0000, 0, 0), 1'b1);
        step("post3", mk(1, 4'h4, 0, 1, 1, 1, 16'h4321, 4, 0), 1'b1);
        step("post4", mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 0, 1), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/bs_rotate_collector.md
# bs_rotate_collector

Downstream stage of the 4-bit rotate-right barrel shifter. Accepts the shifter's 4-bit results one per handshake and packs N consecutive results LSB-first into a wide word. Presents that word on a registered valid/ready output with a running word count. Supports a flush request that emits a partial word zero-padded in the upper nibbles.

## Interface
- DW, 4: nibble width; must equal the rotator data width.
- N, 4: nibbles per packed word; 2..8.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_Y  input  DW  rotator result (o_Y of the barrel shifter).
- i_valid  input  1  i_Y is valid this cycle.
- o_ready  output  1  collector accepts i_Y this cycle.
- i_flush  input  1  level request to emit the current partial word.
- o_word  output  DW*N  packed word; nibble k in bits [DW*k+DW-1 : DW*k].
- o_nvld  output  4  number of valid nibbles in o_word (1..N).
- o_valid  output  1  o_word/o_nvld valid.
- i_ready  input  1  consumer accepts o_word.
- o_wcnt  output  8  count of words delivered (output handshakes), wraps.

## Operation
- Input accept: acc = i_valid & o_ready.
- Output handshake: ohs = o_valid & i_ready.
- o_ready = ~(o_valid & (cnt == N-1)). Combinational from registered state only; there is no path from i_ready. A stall bubble on a full pack with a full output register is intended.
- Pack state: cnt 0..N-1 (FILL0..FILL(N-1)) and pack register pk.
- On acc: i_Y is written to nibble slot cnt of pk.
  - If cnt < N-1 and no flush takes effect, cnt increments.
  - If cnt == N-1 (output is necessarily empty), push.
- Push, on the edge:
  - o_word <= pk including the just-accepted nibble; unfilled slots are 0.
  - o_nvld <= filled slots; o_valid <= 1.
  - cnt <= 0; pk <= 0.
- Flush takes effect in a cycle when i_flush=1, o_valid=0, and (cnt>0 or acc).
  - It pushes the partial word; a nibble accepted the same cycle is included.
  - i_flush with cnt==0 and no acc is a no-op.
  - i_flush while o_valid=1 is held off. The requester keeps i_flush high; it takes effect in the first cycle with o_valid=0.
- Output register:
  - On ohs without a same-edge push, o_valid <= 0.
  - o_word/o_nvld hold their value while o_valid=1 and i_ready=0.
- A push can never coincide with o_valid=1, so there is no overwrite path.
- o_wcnt increments by 1 on each ohs; 8'hFF wraps to 0.

## Timing
- Reset values: o_valid=0, o_word=0, o_nvld=0, o_wcnt=0, cnt=0, pk=0. o_ready=1 immediately after reset deassertion.
- Reset mid-operation discards the partial pack and any pending output word; o_wcnt clears.
- Latency: o_valid rises the cycle after the push edge, i.e. 1 cycle after the Nth nibble is accepted or the flush takes effect.
- After ohs frees the output, o_ready (if low) rises in the next cycle.
- Sustained throughput with i_ready=1: N nibbles per N cycles, no bubbles. While o_valid=1 and i_ready=0, up to N-1 further nibbles are accepted, then o_ready drops.
- i_Y is sampled only on acc; its value on other cycles is don't-care.

## Test plan
- Basic pack: N=4, i_ready=1, nibbles 1,2,3,4 on consecutive cycles -> o_word=16'h4321, o_nvld=4, o_valid one cycle after the 4th accept, o_wcnt=1 after the handshake.
- Backpressure: i_ready=0, offer 8 nibbles 1..8 -> first word 16'h4321 held. o_ready=1 for 5,6,7, then 0 with cnt=3 and 8 not accepted. Raise i_ready -> handshake, o_ready=1 next cycle, 8 accepted -> o_word=16'h8765.
- Flush partial: accept A,B, then i_flush=1 -> o_word=16'h00BA, o_nvld=2. Flush with cnt=0 -> no output.
- Flush simultaneous with valid: cnt=1 (nibble 5), same cycle i_valid with 6 and i_flush=1 -> o_word=16'h0065, o_nvld=2, cnt=0.
- Flush held off: o_valid=1, i_ready=0, cnt=2, i_flush held -> no change until ohs, then partial word emitted the cycle after.
- Counter wrap and reset: deliver 256 words -> o_wcnt=0. Assert i_rst with cnt=2 and o_valid=1 -> all outputs zero, o_ready=1, and a subsequent 1,2,3,4 gives 16'h4321.
